// File: rtl/int2float_arb_pkg.sv
// int2float_arb_pkg: shared constants, tag record and sizing helper for the int2float arbiter.
package int2float_arb_pkg;

    localparam int DEFAULT_LATENCY = 5;
    // Tag index field is wide enough for up to 256 requesters; only the low clog2_min1(N_REQ) bits are used.
    localparam int TAG_IDX_MAX = 8;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                   valid;
        logic [TAG_IDX_MAX-1:0] idx;
    } tag_t;

endpackage

// File: rtl/int2float_rr_arb.sv
// int2float_rr_arb: round-robin priority picker, first requester at or after ptr wins.
module int2float_rr_arb #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] gidx
);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest candidate back to ptr so the nearest valid requester is written last.
    always_comb begin
        grant = '0;
        gidx  = ptr;
        idx   = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % N_REQ);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

endmodule

// File: rtl/int2float_share_arb.sv
// int2float_share_arb: shares one fixed-latency int-to-float converter among N_REQ requesters,
// routing each result back to its requester through a tag pipe aligned with the converter.
module int2float_share_arb
    import int2float_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int N_REQ   = 4,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    conv_start,
    output logic [DATA_W-1:0]       conv_op,
    input  logic [DATA_W-1:0]       conv_res,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]       resp_data,
    output logic                    busy
);

    localparam int IDX_W = clog2_min1(N_REQ);
    localparam int CNT_W = $clog2(LATENCY + 3);

    logic [IDX_W-1:0]  ptr_q, ptr_d, gidx;
    logic [N_REQ-1:0]  grant;
    logic              fire, any_tag;
    logic              conv_start_q, conv_start_d;
    logic [DATA_W-1:0] conv_op_q, conv_op_d;
    logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Stage 0 sits alongside conv_op; stage LATENCY lines up with conv_res.
    tag_t              tag_q [LATENCY+1];
    tag_t              tag_d [LATENCY+1];

    int2float_rr_arb #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) u_arb (
        .req  (req_valid),
        .ptr  (ptr_q),
        .grant(grant),
        .gidx (gidx)
    );

    assign req_ready = rst ? '0 : grant;
    assign fire      = |(req_valid & req_ready);

    always_comb begin
        ptr_d        = fire ? ((gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + 1'b1) : ptr_q;
        conv_op_d    = fire ? req_data[gidx*DATA_W +: DATA_W] : conv_op_q;
        conv_start_d = fire;
        tag_d[0]     = {fire, TAG_IDX_MAX'(gidx)};
        any_tag      = 1'b0;
        for (int i = 1; i <= LATENCY; i++) tag_d[i] = tag_q[i-1];
        for (int i = 0; i <= LATENCY; i++) any_tag = any_tag | tag_q[i].valid;
        resp_valid_d = tag_q[LATENCY].valid ? N_REQ'(1) << tag_q[LATENCY].idx : '0;
        resp_data_d  = tag_q[LATENCY].valid ? conv_res : resp_data_q;
        cnt_d        = cnt_q + CNT_W'(fire) - CNT_W'(|resp_valid_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            conv_start_q <= 1'b0;
            conv_op_q    <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            cnt_q        <= '0;
            for (int i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
        end else begin
            ptr_q        <= ptr_d;
            conv_start_q <= conv_start_d;
            conv_op_q    <= conv_op_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            cnt_q        <= cnt_d;
            for (int i = 0; i <= LATENCY; i++) tag_q[i] <= tag_d[i];
        end
    end

    assign conv_start = conv_start_q;
    assign conv_op    = conv_op_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign busy       = conv_start_q | any_tag | (cnt_q != '0);

endmodule

// File: tb/tb_int2float_share_arb.sv
// tb_int2float_share_arb: directed table-driven bench with a behavioural 5-cycle int-to-float converter.
module tb_int2float_share_arb;

    localparam int DW  = 32;
    localparam int NR  = 4;
    localparam int LAT = 5;
    localparam int RL  = LAT + 2;

    typedef struct {
        logic [NR-1:0]    v;
        logic [NR*DW-1:0] d;
        logic [NR-1:0]    er;
        logic [DW-1:0]    eres;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]    req_ready, resp_valid;
    logic             conv_start, busy;
    logic [DW-1:0]    conv_op, conv_res, resp_data;

    logic [DW-1:0] cp [LAT];
    logic [NR-1:0] exp_rv [512];
    logic [DW-1:0] exp_rd [512];
    logic          issue  [512];
    logic [DW-1:0] rot_exp [8];
    vec_t          vq [$];
    int            cyc, checks, errors;

    always #5 clk = ~clk;

    int2float_share_arb #(
        .DATA_W (DW),
        .N_REQ  (NR),
        .LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .conv_start(conv_start),
        .conv_op   (conv_op),
        .conv_res  (conv_res),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .busy      (busy)
    );

    function automatic logic [31:0] i2f(input logic [31:0] x);
        logic        s;
        logic [31:0] m, keep, rem, half;
        int          e, sh;
        if (x == 32'h0) return 32'h0;
        s = x[31];
        m = s ? (~x + 32'h1) : x;
        e = 31;
        while (!m[e]) e--;
        if (e <= 23) return {s, 8'(127 + e), 23'(m << (23 - e))};
        sh   = e - 23;
        keep = m >> sh;
        rem  = m & ((32'h1 << sh) - 32'h1);
        half = 32'h1 << (sh - 1);
        if (rem > half || (rem == half && keep[0])) keep++;
        if (keep[24]) begin
            keep = keep >> 1;
            e++;
        end
        return {s, 8'(127 + e), keep[22:0]};
    endfunction

    always @(posedge clk) begin
        cp[0] <= i2f(conv_op);
        for (int i = 1; i < LAT; i++) cp[i] <= cp[i-1];
    end
    assign conv_res = cp[LAT-1];

    function automatic logic [NR*DW-1:0] mk(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic bexp(input int c);
        logic r = 1'b0;
        for (int k = 1; k <= RL; k++) r = r | issue[c-k];
        return r;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
        end
    endtask

    task automatic clear_sb();
        for (int i = 0; i < 512; i++) begin
            exp_rv[i] = '0;
            exp_rd[i] = '0;
            issue[i]  = 1'b0;
        end
    endtask

    task automatic add(input logic [NR-1:0] v, input logic [NR*DW-1:0] d,
                       input logic [NR-1:0] er, input logic [DW-1:0] eres);
        vq.push_back('{v, d, er, eres});
    endtask

    // One cycle: check registered outputs, drive inputs, check grant, schedule the expected response.
    task automatic step(input logic [NR-1:0] v, input logic [NR*DW-1:0] d,
                        input logic [NR-1:0] er, input logic [DW-1:0] eres);
        @(negedge clk);
        cyc++;
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv[cyc]));
        if (exp_rv[cyc] != '0) chk("resp_data", resp_data, exp_rd[cyc]);
        chk("busy", 32'(busy), 32'(bexp(cyc)));
        chk("conv_start", 32'(conv_start), 32'(issue[cyc-1]));
        req_valid = v;
        req_data  = d;
        #1;
        chk("req_ready", 32'(req_ready), 32'(er));
        if (er != '0) begin
            issue[cyc]     = 1'b1;
            exp_rv[cyc+RL] = er;
            exp_rd[cyc+RL] = eres;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 8;
        clear_sb();
        rot_exp = '{32'h41200000, 32'h41300000, 32'h41400000, 32'h41500000,
                    32'h41600000, 32'h41700000, 32'h41800000, 32'h41880000};
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_conv_op", conv_op, 32'h0);
        chk("rst_conv_start", 32'(conv_start), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        rst = 1'b0;

        // Contention: all valid, data i = i+2, grants rotate 0..3.
        add(4'hF, mk(2, 3, 4, 5), 4'b0001, 32'h40000000);
        add(4'hF, mk(2, 3, 4, 5), 4'b0010, 32'h40400000);
        add(4'hF, mk(2, 3, 4, 5), 4'b0100, 32'h40800000);
        add(4'hF, mk(2, 3, 4, 5), 4'b1000, 32'h40A00000);
        // Single request from requester 2.
        add(4'b0100, mk(0, 0, 1, 0), 4'b0100, 32'h3F800000);
        for (int i = 0; i < 8; i++) add('0, '0, '0, '0);
        // Rotation: grant 3, then 0 and 3 again, then 3 back-to-back.
        add(4'b1000, mk(0, 0, 0, 7), 4'b1000, 32'h40E00000);
        add(4'b1001, mk(8, 0, 0, 9), 4'b0001, 32'h41000000);
        add(4'b1000, mk(0, 0, 0, 9), 4'b1000, 32'h41100000);
        for (int i = 0; i < 8; i++) add(4'b1000, mk(0, 0, 0, 32'(10 + i)), 4'b1000, rot_exp[i]);
        for (int i = 0; i < 8; i++) add('0, '0, '0, '0);
        // Negative and zero, routed to requesters 1 and 0.
        add(4'b0010, mk(0, 32'hFFFFFFFF, 0, 0), 4'b0010, 32'hBF800000);
        add(4'b0001, mk(0, 0, 0, 0), 4'b0001, 32'h00000000);
        // Drain and then a long idle stretch.
        for (int i = 0; i < 28; i++) add('0, '0, '0, '0);
        foreach (vq[i]) step(vq[i].v, vq[i].d, vq[i].er, vq[i].eres);

        // Reset mid-flight: ptr is 1 here, three ops issue, reset lands two cycles later.
        step(4'hF, mk(6, 6, 6, 6), 4'b0010, 32'h40C00000);
        step(4'hF, mk(6, 6, 6, 6), 4'b0100, 32'h40C00000);
        step(4'hF, mk(6, 6, 6, 6), 4'b1000, 32'h40C00000);
        step('0, '0, '0, '0);
        step('0, '0, '0, '0);
        @(negedge clk);
        rst = 1'b1;
        clear_sb();
        #1;
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_conv_start", 32'(conv_start), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step('0, '0, '0, '0);
        step(4'hF, mk(32, 0, 0, 0), 4'b0001, 32'h42000000);
        for (int i = 0; i < 9; i++) step('0, '0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
